// File: rtl/eth_tx_pkg.sv
// Shared definitions for the frame-granular GMII transmit arbiter.
package eth_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2,
        ST_IFG   = 2'd3
    } tx_state_e;

    localparam int IFG_CYCLES_DEF = 12;

    localparam int SRC_ARP  = 0;
    localparam int SRC_UDP  = 1;
    localparam int SRC_ICMP = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eth_tx_rr_pick.sv
// Combinational round-robin picker: first eligible requester after ptr,
// wrapping modulo NUM_SRC; masked requesters are never eligible.
module eth_tx_rr_pick #(
    parameter int NUM_SRC = 3,
    parameter int IW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] mask,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_SRC-1:0] onehot,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    localparam logic [IW-1:0] LAST = IW'(NUM_SRC - 1);

    logic [NUM_SRC-1:0] eligible;
    logic [IW-1:0]      cand;

    always_comb begin
        eligible = req & ~mask;
        valid    = 1'b0;
        idx      = '0;
        cand     = ptr;
        // Walk ptr+1 .. ptr+NUM_SRC so the last winner has lowest priority.
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = (cand == LAST) ? '0 : cand + IW'(1);
            if (!valid && eligible[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
        onehot = valid ? (NUM_SRC'(1) << idx) : '0;
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin, frame-granular arbiter sharing one GMII TX port between sources.
// Define ETH_TX_WDOG_EN to enable the stuck-grant watchdog and abort mask.
module eth_tx_arbiter
    import eth_tx_pkg::*;
#(
    parameter int NUM_SRC          = 3,
    parameter int IFG_CYCLES       = IFG_CYCLES_DEF,
    parameter int START_TIMEOUT    = 64,
    parameter int MAX_FRAME_CYCLES = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_req,
    output logic [NUM_SRC-1:0]   src_gnt,
    input  logic [NUM_SRC-1:0]   src_tx_en,
    input  logic [8*NUM_SRC-1:0] src_txd,
    output logic                 gmii_tx_en,
    output logic [7:0]           gmii_txd,
    output logic                 busy,
    output logic [2:0]           cur_src,
    output logic                 wdog_abort
);

    localparam int IW  = $clog2(NUM_SRC);
    localparam int ICW = $clog2(IFG_CYCLES + 1);
    localparam logic [ICW-1:0] IFG_LOAD = ICW'(IFG_CYCLES - 1);

    if (NUM_SRC < 2 || NUM_SRC > 8 || IFG_CYCLES < 1 ||
        START_TIMEOUT < 1 || MAX_FRAME_CYCLES < 1) begin : g_bad_param
        $error("eth_tx_arbiter: parameter out of range");
    end

    tx_state_e          state;
    logic [IW-1:0]      ptr;
    logic [ICW-1:0]     ifg_cnt;
    logic [NUM_SRC-1:0] abort_mask;
    logic               wdog_fire;

    logic [NUM_SRC-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               pick_vld;
    logic               sel_req;
    logic               sel_tx_en;
    logic [7:0]         sel_txd;

    eth_tx_rr_pick #(.NUM_SRC(NUM_SRC), .IW(IW)) u_pick (
        .req    (src_req),
        .mask   (abort_mask),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

    // ptr doubles as the active source while a grant is held.
    assign sel_req   = src_req[ptr];
    assign sel_tx_en = src_tx_en[ptr];

    always_comb begin
        sel_txd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ptr == IW'(i)) sel_txd = src_txd[8*i +: 8];
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            src_gnt    <= '0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= '0;
            cur_src    <= '0;
            ptr        <= IW'(NUM_SRC - 1);
            ifg_cnt    <= '0;
        end else if (wdog_fire) begin
            state      <= ST_IFG;
            src_gnt    <= '0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= '0;
            ifg_cnt    <= IFG_LOAD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state   <= ST_GRANT;
                        src_gnt <= pick_oh;
                        ptr     <= pick_idx;
                        cur_src <= 3'(pick_idx);
                    end
                end
                ST_GRANT: begin
                    if (sel_tx_en) begin
                        state      <= ST_SEND;
                        gmii_tx_en <= 1'b1;
                        gmii_txd   <= sel_txd;
                    end else if (!sel_req) begin
                        // Abandoned before any data: no gap needed.
                        state   <= ST_IDLE;
                        src_gnt <= '0;
                    end
                end
                ST_SEND: begin
                    if (sel_tx_en) begin
                        gmii_txd <= sel_txd;
                    end else begin
                        state      <= ST_IFG;
                        src_gnt    <= '0;
                        gmii_tx_en <= 1'b0;
                        gmii_txd   <= '0;
                        ifg_cnt    <= IFG_LOAD;
                    end
                end
                ST_IFG: begin
                    if (ifg_cnt == '0) state <= ST_IDLE;
                    else               ifg_cnt <= ifg_cnt - ICW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ETH_TX_WDOG_EN
    localparam int TW = $clog2(max2(START_TIMEOUT, MAX_FRAME_CYCLES) + 1);

    logic [TW-1:0] tmr;

    // Normal exits (tx_en seen, req dropped, frame end) take precedence.
    assign wdog_fire =
        (state == ST_GRANT && !sel_tx_en && sel_req && tmr == TW'(START_TIMEOUT - 1)) ||
        (state == ST_SEND  &&  sel_tx_en && tmr == TW'(MAX_FRAME_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr        <= '0;
            abort_mask <= '0;
            wdog_abort <= 1'b0;
        end else begin
            wdog_abort <= wdog_fire;
            if (state == ST_IDLE || state == ST_IFG || (state == ST_GRANT && sel_tx_en))
                tmr <= '0;
            else
                tmr <= tmr + TW'(1);
            // An aborted source stays out until it has gone fully quiet.
            abort_mask <= (abort_mask & (src_tx_en | src_req)) | (wdog_fire ? src_gnt : '0);
        end
    end
`else
    assign wdog_fire  = 1'b0;
    assign abort_mask = '0;
    assign wdog_abort = 1'b0;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: directed table, corner sequences, and random
// traffic checked against a transaction-level arbitration model.
module tb_eth_tx_arbiter;

    localparam int N   = 3;
    localparam int IFG = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   src_req = '0;
    logic [N-1:0]   src_tx_en = '0;
    logic [8*N-1:0] src_txd = '0;
    logic [N-1:0]   src_gnt;
    logic           gmii_tx_en;
    logic [7:0]     gmii_txd;
    logic           busy;
    logic [2:0]     cur_src;
    logic           wdog_abort;

    eth_tx_arbiter #(
        .NUM_SRC(N), .IFG_CYCLES(IFG), .START_TIMEOUT(64), .MAX_FRAME_CYCLES(100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_req    (src_req),
        .src_gnt    (src_gnt),
        .src_tx_en  (src_tx_en),
        .src_txd    (src_txd),
        .gmii_tx_en (gmii_tx_en),
        .gmii_txd   (gmii_txd),
        .busy       (busy),
        .cur_src    (cur_src),
        .wdog_abort (wdog_abort)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    int t     = 0;

    function automatic logic [16:0] pk(input logic [2:0] g, input logic e, input logic [7:0] d,
                                       input logic b, input logic [2:0] c);
        return {g, e, d, b, c, 1'b0};
    endfunction

    task automatic check_out(input string name, input logic [16:0] want);
        logic [16:0] got;
        got = {src_gnt, gmii_tx_en, gmii_txd, busy, cur_src, wdog_abort};
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s @t=%0d: got gnt=%b en=%b txd=%h busy=%b cur=%0d abort=%b, want gnt=%b en=%b txd=%h busy=%b cur=%0d abort=%b",
                     name, t, got[16:14], got[13], got[12:5], got[4], got[3:1], got[0],
                     want[16:14], want[13], want[12:5], want[4], want[3:1], want[0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s @t=%0d: got %0d, want %0d", name, t, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Reference model: who owns the port, and from which cycle arbitration may resume.
    int          m_owner, m_last, m_ready, m_cyc;
    bit          m_started;
    logic [2:0]  m_cur;
    logic [16:0] m_exp;

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_ready = 0; m_cyc = 0;
        m_started = 0; m_cur = 3'd0;
    endtask

    task automatic model_step();
        logic       en;
        logic [7:0] d;
        logic [2:0] g;
        logic       b;
        en = 1'b0; d = 8'h00;
        if (m_owner < 0) begin
            if (m_cyc >= m_ready && src_req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    int s;
                    s = (m_last + k) % N;
                    if (m_owner < 0 && src_req[s]) m_owner = s;
                end
                m_last = m_owner; m_cur = 3'(m_owner); m_started = 0;
            end
        end else if (src_tx_en[m_owner]) begin
            m_started = 1; en = 1'b1; d = src_txd[8*m_owner +: 8];
        end else if (m_started) begin
            m_owner = -1; m_ready = m_cyc + IFG + 1;
        end else if (!src_req[m_owner]) begin
            m_owner = -1; m_ready = m_cyc + 1;
        end
        m_cyc++;
        g = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        b = (m_owner >= 0) || (m_cyc < m_ready);
        m_exp = pk(g, en, d, b, m_cur);
    endtask

    task automatic do_reset();
        rst = 1'b1; src_req = '0; src_tx_en = '0; src_txd = '0;
        step(); step();
        check_out("reset", pk(3'b000, 1'b0, 8'h00, 1'b0, 3'd0));
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [2:0]  req, tx;
        logic [23:0] txd;
        int          rep;
        logic [2:0]  gnt;
        logic        en;
        logic [7:0]  dat;
        logic        busy;
        logic [2:0]  cur;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int w, waited, drop, en_cnt, ab_cnt, gnt_seen;

        tbl[0]  = '{3'b000, 3'b000, 24'h000000,  1, 3'b000, 1'b0, 8'h00, 1'b0, 3'd0};
        tbl[1]  = '{3'b010, 3'b000, 24'h000000,  1, 3'b010, 1'b0, 8'h00, 1'b1, 3'd1};
        tbl[2]  = '{3'b000, 3'b000, 24'h000000,  1, 3'b000, 1'b0, 8'h00, 1'b0, 3'd1};
        tbl[3]  = '{3'b101, 3'b000, 24'h000000,  1, 3'b100, 1'b0, 8'h00, 1'b1, 3'd2};
        tbl[4]  = '{3'b101, 3'b001, 24'h000011,  1, 3'b100, 1'b0, 8'h00, 1'b1, 3'd2};
        tbl[5]  = '{3'b101, 3'b100, 24'h3C0000,  1, 3'b100, 1'b1, 8'h3C, 1'b1, 3'd2};
        tbl[6]  = '{3'b101, 3'b101, 24'hC30022,  1, 3'b100, 1'b1, 8'hC3, 1'b1, 3'd2};
        tbl[7]  = '{3'b101, 3'b000, 24'h5A5A5A,  1, 3'b000, 1'b0, 8'h00, 1'b1, 3'd2};
        tbl[8]  = '{3'b111, 3'b000, 24'h000000, 11, 3'b000, 1'b0, 8'h00, 1'b1, 3'd2};
        tbl[9]  = '{3'b111, 3'b000, 24'h000000,  1, 3'b000, 1'b0, 8'h00, 1'b0, 3'd2};
        tbl[10] = '{3'b111, 3'b000, 24'h000000,  1, 3'b001, 1'b0, 8'h00, 1'b1, 3'd0};
        tbl[11] = '{3'b000, 3'b000, 24'h000000,  1, 3'b000, 1'b0, 8'h00, 1'b0, 3'd0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                src_req = tbl[i].req; src_tx_en = tbl[i].tx; src_txd = tbl[i].txd;
                step();
                check_out($sformatf("tbl%0d", i),
                          pk(tbl[i].gnt, tbl[i].en, tbl[i].dat, tbl[i].busy, tbl[i].cur));
            end
        end

        // Single 64-byte UDP frame with noise on the ungranted ARP source.
        do_reset();
        repeat (9) step();
        src_req = 3'b010;
        step();
        check_out("udp_gnt", pk(3'b010, 1'b0, 8'h00, 1'b1, 3'd1));
        for (int i = 0; i < 64; i++) begin
            src_tx_en = 3'b011;
            src_txd   = {8'h00, 8'(i), 8'hFF};
            step();
            check_out("udp_byte", pk(3'b010, 1'b1, 8'(i), 1'b1, 3'd1));
        end
        src_tx_en = '0; src_req = '0;
        step();
        check_out("udp_end", pk(3'b000, 1'b0, 8'h00, 1'b1, 3'd1));

        // All sources requesting: strict rotation, next grant exactly m+14.
        do_reset();
        src_req = 3'b111;
        drop = 0;
        for (int f = 0; f < 4; f++) begin
            waited = 0;
            while (src_gnt == '0 && waited < 40) begin
                step();
                waited++;
            end
            w = -1;
            for (int i = 0; i < N; i++) if (src_gnt[i]) w = i;
            check_int("rr_order", w, f % 3);
            if (f > 0) check_int("rr_gnt_delay", t - drop, IFG + 2);
            if (w < 0) break;
            for (int b = 0; b < 4; b++) begin
                src_tx_en = 3'(1 << w);
                src_txd   = '0;
                src_txd[8*w +: 8] = 8'(16*f + b);
                step();
                check_out("rr_data", pk(3'(1 << (f % 3)), 1'b1, 8'(16*f + b), 1'b1, 3'(f % 3)));
            end
            src_tx_en = '0;
            drop = t;
            step();
            check_out("rr_frame_end", pk(3'b000, 1'b0, 8'h00, 1'b1, 3'(f % 3)));
        end
        src_req = '0;

        // Reset mid-frame, then sources 0 and 2 compete: 0 wins.
        do_reset();
        src_req = 3'b100;
        step();
        src_tx_en = 3'b100; src_txd = 24'h770000;
        step();
        check_out("pre_rst", pk(3'b100, 1'b1, 8'h77, 1'b1, 3'd2));
        rst = 1'b1;
        step();
        check_out("rst_mid_frame", pk(3'b000, 1'b0, 8'h00, 1'b0, 3'd0));
        rst = 1'b0; src_tx_en = '0; src_req = 3'b101;
        step();
        check_out("rst_first_pick", pk(3'b001, 1'b0, 8'h00, 1'b1, 3'd0));
        src_req = '0;
        step();
        check_out("rst_abandon", pk(3'b000, 1'b0, 8'h00, 1'b0, 3'd0));

`ifdef ETH_TX_WDOG_EN
        // Over-long frame: cut after 100 cycles, one abort pulse, source masked.
        do_reset();
        src_req = 3'b010;
        step();
        check_out("wdog_gnt", pk(3'b010, 1'b0, 8'h00, 1'b1, 3'd1));
        src_tx_en = 3'b010; src_txd = 24'h00AB00;
        en_cnt = 0; ab_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (gmii_tx_en) en_cnt++;
            if (wdog_abort) ab_cnt++;
        end
        check_int("wdog_frame_len", en_cnt, 100);
        check_int("wdog_pulses", ab_cnt, 1);
        check_out("wdog_after", pk(3'b000, 1'b0, 8'h00, 1'b0, 3'd1));
        src_tx_en = '0;
        gnt_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (src_gnt != '0) gnt_seen = 1;
        end
        check_int("wdog_masked", gnt_seen, 0);
        src_req = '0;
        step();
        src_req = 3'b010;
        step();
        check_out("wdog_unmask", pk(3'b010, 1'b0, 8'h00, 1'b1, 3'd1));
        src_req = '0;
        step();
`endif

        // Random traffic with persistent req/tx_en levels and noisy idle sources.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) src_req[i]   = ~src_req[i];
                if ($urandom_range(3) == 0) src_tx_en[i] = ~src_tx_en[i];
            end
            src_txd = 24'($urandom);
            model_step();
            step();
            check_out("random", m_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Frame-granular GMII transmit arbiter that shares one GMII TX port between up to NUM_SRC frame generators (ARP reply, UDP video, ICMP echo) using a req/gnt handshake. It sits between the protocol TX engines and the GMII/RGMII output stage, replacing ad-hoc two-way protocol switching. Grants are round-robin, never interrupt a frame, and enforce a minimum inter-frame gap. An optional watchdog releases stuck grants.

## Interface
- NUM_SRC, 3, number of requesters (2..8); index 0 = ARP, 1 = UDP, 2 = ICMP
- IFG_CYCLES, 12, minimum idle cycles inserted after each frame
- START_TIMEOUT, 64, watchdog: max cycles from gnt to first tx_en
- MAX_FRAME_CYCLES, 2048, watchdog: max cycles tx_en may stay high
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- src_req  in  NUM_SRC  per-source frame request, level
- src_gnt  out  NUM_SRC  one-hot grant, level, registered
- src_tx_en  in  NUM_SRC  per-source GMII data valid
- src_txd  in  8*NUM_SRC  per-source GMII data, source i at bits [8i+7:8i]
- gmii_tx_en  out  1  muxed data valid, registered
- gmii_txd  out  8  muxed data, registered
- busy  out  1  high in any state other than IDLE
- cur_src  out  3  index of granted source; holds last value when idle
- wdog_abort  out  1  one-cycle pulse on watchdog release

## Operation
- States: IDLE, GRANT, SEND, IFG.
- IDLE: if any unmasked src_req, pick winner via round-robin starting at (last granted + 1) mod NUM_SRC; next cycle GRANT with src_gnt[winner]=1, cur_src=winner, pointer updated.
- GRANT: src_tx_en[winner]=1 → SEND. src_req[winner]=0 before any tx_en → IDLE, gnt cleared, no IFG.
- SEND: gmii_tx_en/txd follow src_tx_en/txd[winner]. First cycle with src_tx_en[winner]=0 ends frame → IFG; gnt cleared on entry to IFG.
- IFG: counter runs IFG_CYCLES cycles, then IDLE. src_req ignored.
- Non-granted sources' tx_en/txd never reach the output. gmii_txd = 0 whenever gmii_tx_en = 0.
- src_req sampled only in IDLE; a source may keep req high across frames and is re-served after others per round-robin.
- Reset: src_gnt=0, gmii_tx_en=0, gmii_txd=0, busy=0, cur_src=0, wdog_abort=0, pointer=NUM_SRC-1 (so source 0 wins first), abort mask=0, state IDLE. Reset mid-frame truncates output on the next edge.

## Timing
- req high at edge N in IDLE → src_gnt high from N+1.
- src_tx_en[winner] at cycle k → gmii_tx_en/txd at k+1 (fixed 1-cycle latency, no bubble).
- tx_en first low at cycle m → gmii_tx_en low and gnt low at m+1; IFG occupies m+1..m+IFG_CYCLES; IDLE at m+IFG_CYCLES+1; earliest next gnt at m+IFG_CYCLES+2.
- Simultaneous req from all sources: served strictly in rotation, one frame each.

## Configuration
- ETH_TX_WDOG_EN defined: GRANT lasting START_TIMEOUT cycles, or SEND lasting MAX_FRAME_CYCLES cycles, forces gnt=0, gmii_tx_en=0 next cycle, wdog_abort pulse, state IFG. The aborted source is masked from arbitration until its src_tx_en and src_req are both seen low.
- Not defined: no timers, no mask; wdog_abort tied 0; START_TIMEOUT/MAX_FRAME_CYCLES unused.

## Structure
- Shared package eth_tx_pkg: state encoding constants, default IFG_CYCLES, source index constants (SRC_ARP=0, SRC_UDP=1, SRC_ICMP=2).
- One sub-module eth_tx_rr_pick: combinational round-robin picker (req vector, pointer, mask → one-hot winner + index + valid).

## Test plan
- Single UDP frame: req[1] at cycle 10, tx_en 64 cycles from gnt+1 → gnt[1] at 11, gmii_tx_en exactly 64 cycles, data bytes 0x00..0x3F intact, 1-cycle latency.
- All three req held: frames served order 0,1,2,0; gmii idle gap ≥ 12 cycles between each.
- ARP req during UDP frame: UDP frame uninterrupted; gnt[0] earliest m+14 after UDP tx_en drop at m.
- Requester drops req in GRANT without tx_en → IDLE next cycle, no IFG, busy low, gmii_tx_en stays 0.
- rst asserted mid-frame → next edge all outputs 0; first req after reset from sources 0 and 2 → source 0 wins.
- With ETH_TX_WDOG_EN, MAX_FRAME_CYCLES=100, source holds tx_en 150 cycles → gmii_tx_en drops after 100, wdog_abort one pulse, source masked until tx_en low.
